aoi_exhaustive_checker: RTL and testbench
=========================================

// Module: aoi_exhaustive_checker
// PURPOSE
//  Self-checking exhaustive stimulus/compare engine for AND-OR-INVERT style standard cells.
//  Sweeps all 2^N input vectors into a DUT cell and waits SETTLE cycles per vector.
//  Compares the DUT output against a built-in golden model, then reports pass/fail, error
//  count and first failing vector. Replaces hand-written per-cell truth-table benches
//  (AOI222 family and relatives).
// PARAMETERS
//  GROUPS   3  number of AND (or OR) groups feeding the final gate, >=1
//  GROUP_W  2  inputs per group, >=1; N = GROUPS*GROUP_W (localparam), N<=16
//  MODE     0  0=AOI ~|(&g), 1=AO |(&g), 2=OAI ~&(|g), 3=OA &(|g)
//  SETTLE   2  cycles a vector is held before sampling, >=1
// PORTS
//  clk             in   1    clock, rising edge
//  rst             in   1    asynchronous, active-high reset
//  start           in   1    1-cycle pulse; begins sweep from IDLE or DONE
//  abort           in   1    terminate sweep, return to IDLE
//  vec_o           out  N    DUT inputs; bit N-1 = group0 input1 (A1) ... bit 0 = last input (C2)
//  dut_zn          in   1    DUT output
//  busy            out  1    sweep in progress
//  done            out  1    sweep complete; held until next start/abort/reset
//  pass            out  1    valid with done: err_cnt==0
//  err_cnt         out  N+1  mismatching vectors (max 2^N, cannot overflow)
//  first_fail_vld  out  1    at least one mismatch recorded
//  first_fail_vec  out  N    lowest-valued failing vector
// BEHAVIOUR
//  Reset: state=IDLE; vec_o=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vld=0,
//    first_fail_vec=0. Reset mid-sweep aborts immediately; no partial result retained.
//  Group g occupies vec_o[N-1-g*GROUP_W -: GROUP_W]; golden output is per MODE above.
//  FSM IDLE -> APPLY -> SAMPLE -> (APPLY | DONE); any state -> IDLE on abort.
//  IDLE: outputs static. start: vec_o<=0, settle_cnt<=0, clear err_cnt/first_fail/pass/done,
//    busy<=1, go APPLY.
//  APPLY: settle_cnt++ per cycle; when settle_cnt==SETTLE-1, go SAMPLE.
//  SAMPLE: compare registered dut_zn with golden(vec_o). On mismatch: err_cnt++.
//    If !first_fail_vld: first_fail_vec<=vec_o, first_fail_vld<=1.
//    If vec_o==all-ones: busy<=0, done<=1, pass<=(err_cnt_next==0), go DONE.
//    Else: vec_o++, settle_cnt<=0, go APPLY.
//  Per-vector cost is SETTLE+1 cycles. Sweep time is 2^N*(SETTLE+1) cycles from the start
//    edge to done high.
//  DONE: results held stable; start restarts (stats cleared same edge); abort -> IDLE with
//    done=0, results held.
//  start while busy: ignored. abort and start in same cycle: abort wins.
//  abort in any state: next edge state=IDLE, busy=0, done=0, vec_o=0.
//  vec_o, busy and done are registered; no combinational path from dut_zn to outputs.
// STRUCTURE
//  Package cell_test_pkg: state enum {IDLE,APPLY,SAMPLE,DONE}; mode constants
//    MODE_AOI/AO/OAI/OA; function golden_eval(vec, GROUPS, GROUP_W, MODE).
//  Sub-module cell_golden_model: combinational golden output from vec_o (wraps golden_eval),
//    reusable by other cell benches.
//  Top: FSM, vector counter, settle counter, error/first-fail registers.
// TESTING
//  1 Defaults, behavioural AOI222 DUT, start pulse -> busy 192 cycles, then done=1, pass=1,
//    err_cnt=0, first_fail_vld=0.
//  2 Defaults, DUT stuck-at-1 -> done, pass=0, err_cnt=37, first_fail_vec=6'b000011.
//  3 Defaults, DUT stuck-at-0 -> err_cnt=27, first_fail_vec=6'b000000.
//  4 abort while vec_o=10 -> next cycle state IDLE, busy=0, done=0, vec_o=0. A later start
//    sweeps from 0, and the result matches test 1.
//  5 rst asserted asynchronously mid-APPLY -> all outputs to reset values immediately.
//    start after release gives a full clean sweep.
//  6 GROUPS=2, GROUP_W=3, MODE=2, SETTLE=1, correct OAI33 DUT -> done after 128 cycles,
//    pass=1. Then start from DONE -> err_cnt and done clear on that edge, and the sweep repeats.

Source files
------------

// File: rtl/cell_test_pkg.sv
// -----------------------------------------------------------------------------
// cell_test_pkg
// Purpose : Shared types and helpers for exhaustive standard-cell checkers.
//           Provides the checker FSM state enum, the cell-family mode codes and
//           a golden evaluation function for AND-OR-INVERT style cells.
// Contents:
//   state_t      IDLE / APPLY / SAMPLE / DONE
//   MODE_*       0=AOI ~|(&g), 1=AO |(&g), 2=OAI ~&(|g), 3=OA &(|g)
//   MAX_N        widest input vector the golden function understands
//   golden_eval  reference output of a cell for one input vector
// -----------------------------------------------------------------------------
package cell_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } state_t;

  localparam int MODE_AOI = 0;
  localparam int MODE_AO  = 1;
  localparam int MODE_OAI = 2;
  localparam int MODE_OA  = 3;

  localparam int MAX_N = 16;

  // Evaluates the cell for one vector. Group g occupies the bits
  // vec[n-1-g*group_w -: group_w], so group 0 input 1 sits on the MSB.
  // AOI/AO reduce each group with AND and combine groups with OR; OAI/OA do
  // the opposite. The loops run to the fixed MAX_N bound so the function
  // stays synthesizable for any legal parameter set.
  function automatic logic golden_eval(input logic [MAX_N-1:0] vec,
                                       input int groups,
                                       input int group_w,
                                       input int mode);
    logic and_first;
    logic inverted;
    logic acc;
    logic grp;
    logic b;
    int   idx;
    int   n;
    n         = groups * group_w;
    and_first = (mode == MODE_AOI) || (mode == MODE_AO);
    inverted  = (mode == MODE_AOI) || (mode == MODE_OAI);
    acc       = and_first ? 1'b0 : 1'b1;
    for (int g = 0; g < MAX_N; g++) begin
      if (g < groups) begin
        grp = and_first ? 1'b1 : 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
          if (i < group_w) begin
            idx = n - 1 - g * group_w - i;
            b   = (idx >= 0 && idx < MAX_N) ? vec[idx[3:0]] : 1'b0;
            grp = and_first ? (grp & b) : (grp | b);
          end
        end
        acc = and_first ? (acc | grp) : (acc & grp);
      end
    end
    return inverted ? ~acc : acc;
  endfunction

endpackage

// File: rtl/cell_golden_model.sv
// -----------------------------------------------------------------------------
// cell_golden_model
// Purpose : Combinational reference output for an AOI/AO/OAI/OA cell, driven by
//           the same vector that is applied to the cell under test. Reusable
//           by any cell checker.
// Ports   :
//   vec  in  N  cell inputs, bit N-1 = group 0 input 1
//   zn   out 1  expected cell output
// -----------------------------------------------------------------------------
module cell_golden_model
  import cell_test_pkg::*;
#(
  parameter  int GROUPS  = 3,
  parameter  int GROUP_W = 2,
  parameter  int MODE    = MODE_AOI,
  localparam int N       = GROUPS * GROUP_W
) (
  input  logic [N-1:0] vec,
  output logic         zn
);

  // Zero-extend the vector to the package width and evaluate the golden
  // function; the upper padding bits are never indexed for this N.
  always_comb begin
    zn = golden_eval(MAX_N'(vec), GROUPS, GROUP_W, MODE);
  end

endmodule

// File: rtl/aoi_exhaustive_checker.sv
// -----------------------------------------------------------------------------
// aoi_exhaustive_checker
// Purpose : Exhaustive stimulus/compare engine for AND-OR-INVERT style cells.
//           Walks all 2^N input vectors, holds each for SETTLE cycles, then
//           compares the cell output with the golden model and accumulates an
//           error count and the lowest failing vector.
// Ports   :
//   clk             in   1    clock, rising edge
//   rst             in   1    asynchronous active-high reset
//   start           in   1    begin a sweep from IDLE or DONE
//   abort           in   1    end the sweep, return to IDLE (beats start)
//   vec_o           out  N    cell inputs, bit N-1 = group 0 input 1
//   dut_zn          in   1    cell output
//   busy            out  1    sweep in progress
//   done            out  1    sweep complete, held until start/abort/reset
//   pass            out  1    with done: no mismatches
//   err_cnt         out  N+1  number of mismatching vectors
//   first_fail_vld  out  1    at least one mismatch recorded
//   first_fail_vec  out  N    lowest-valued failing vector
// -----------------------------------------------------------------------------
module aoi_exhaustive_checker
  import cell_test_pkg::*;
#(
  parameter  int GROUPS  = 3,
  parameter  int GROUP_W = 2,
  parameter  int MODE    = MODE_AOI,
  parameter  int SETTLE  = 2,
  localparam int N       = GROUPS * GROUP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  output logic [N-1:0] vec_o,
  input  logic         dut_zn,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic         first_fail_vld,
  output logic [N-1:0] first_fail_vec
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_t        state;
  state_t        next_state;
  logic [SW-1:0] settle_cnt;
  logic          dut_zn_q;
  logic          golden_zn;
  logic          mismatch;
  logic          last_vec;
  logic          start_sweep;
  logic [N:0]    err_cnt_next;

  cell_golden_model #(
    .GROUPS  (GROUPS),
    .GROUP_W (GROUP_W),
    .MODE    (MODE)
  ) u_golden (
    .vec (vec_o),
    .zn  (golden_zn)
  );

  // The cell output is registered before comparison so nothing from dut_zn
  // reaches an output combinationally. It is captured on the edge that ends
  // the last settle cycle, i.e. after SETTLE full cycles with the vector held.
  assign mismatch     = (dut_zn_q != golden_zn);
  assign last_vec     = &vec_o;
  assign err_cnt_next = err_cnt + {{N{1'b0}}, mismatch};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Abort overrides everything; start is only honoured in
  // IDLE or DONE so a pulse during a sweep is simply ignored.
  always_comb begin
    next_state  = state;
    start_sweep = 1'b0;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            next_state  = APPLY;
            start_sweep = 1'b1;
          end
        end
        APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            next_state = SAMPLE;
          end
        end
        SAMPLE: begin
          next_state = last_vec ? DONE : APPLY;
        end
        DONE: begin
          if (start) begin
            next_state  = APPLY;
            start_sweep = 1'b1;
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Datapath: vector and settle counters, result registers and status flags.
  // Abort keeps the accumulated results but drops busy/done and parks the
  // vector at zero. A start clears all statistics on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_o          <= '0;
      settle_cnt     <= '0;
      dut_zn_q       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      dut_zn_q <= dut_zn;
      if (abort) begin
        vec_o      <= '0;
        settle_cnt <= '0;
        busy       <= 1'b0;
        done       <= 1'b0;
      end else if (start_sweep) begin
        vec_o          <= '0;
        settle_cnt     <= '0;
        busy           <= 1'b1;
        done           <= 1'b0;
        pass           <= 1'b0;
        err_cnt        <= '0;
        first_fail_vld <= 1'b0;
        first_fail_vec <= '0;
      end else if (state == APPLY) begin
        settle_cnt <= settle_cnt + 1'b1;
      end else if (state == SAMPLE) begin
        err_cnt <= err_cnt_next;
        // Vectors ascend, so the first mismatch seen is the lowest one.
        if (mismatch && !first_fail_vld) begin
          first_fail_vld <= 1'b1;
          first_fail_vec <= vec_o;
        end
        if (last_vec) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_cnt_next == '0);
        end else begin
          vec_o      <= vec_o + 1'b1;
          settle_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_aoi_exhaustive_checker.sv
// -----------------------------------------------------------------------------
// tb_aoi_exhaustive_checker
// Purpose : Self-checking bench for aoi_exhaustive_checker. One checker runs
//           with default parameters against a behavioural AOI222 cell, a
//           second runs as an OAI33 checker with SETTLE=1. Each cell can be
//           forced to stuck-at-1 or stuck-at-0 to create known mismatches.
// -----------------------------------------------------------------------------
module tb_aoi_exhaustive_checker;

  typedef struct {
    int fault;
    int exp_err;
    int exp_pass;
    int exp_vld;
    int exp_vec;
  } sweep_vec_t;

  logic       clk;
  logic       rst;

  logic       start_a;
  logic       abort_a;
  logic [5:0] vec_o_a;
  logic       dut_zn_a;
  logic       busy_a;
  logic       done_a;
  logic       pass_a;
  logic [6:0] err_cnt_a;
  logic       first_fail_vld_a;
  logic [5:0] first_fail_vec_a;
  int         fault_a;

  logic       start_b;
  logic       abort_b;
  logic [5:0] vec_o_b;
  logic       dut_zn_b;
  logic       busy_b;
  logic       done_b;
  logic       pass_b;
  logic [6:0] err_cnt_b;
  logic       first_fail_vld_b;
  logic [5:0] first_fail_vec_b;
  int         fault_b;

  int checks;
  int failures;

  // Behavioural cells: AOI222 and OAI33, with 1 = stuck-at-1, 2 = stuck-at-0.
  always_comb begin
    dut_zn_a = ~((vec_o_a[5] & vec_o_a[4]) | (vec_o_a[3] & vec_o_a[2]) |
                 (vec_o_a[1] & vec_o_a[0]));
    if (fault_a == 1) dut_zn_a = 1'b1;
    if (fault_a == 2) dut_zn_a = 1'b0;
  end

  always_comb begin
    dut_zn_b = ~((vec_o_b[5] | vec_o_b[4] | vec_o_b[3]) &
                 (vec_o_b[2] | vec_o_b[1] | vec_o_b[0]));
    if (fault_b == 1) dut_zn_b = 1'b1;
    if (fault_b == 2) dut_zn_b = 1'b0;
  end

  aoi_exhaustive_checker dut_a (
    .clk            (clk),
    .rst            (rst),
    .start          (start_a),
    .abort          (abort_a),
    .vec_o          (vec_o_a),
    .dut_zn         (dut_zn_a),
    .busy           (busy_a),
    .done           (done_a),
    .pass           (pass_a),
    .err_cnt        (err_cnt_a),
    .first_fail_vld (first_fail_vld_a),
    .first_fail_vec (first_fail_vec_a)
  );

  aoi_exhaustive_checker #(
    .GROUPS  (2),
    .GROUP_W (3),
    .MODE    (2),
    .SETTLE  (1)
  ) dut_b (
    .clk            (clk),
    .rst            (rst),
    .start          (start_b),
    .abort          (abort_b),
    .vec_o          (vec_o_b),
    .dut_zn         (dut_zn_b),
    .busy           (busy_b),
    .done           (done_b),
    .pass           (pass_b),
    .err_cnt        (err_cnt_b),
    .first_fail_vld (first_fail_vld_b),
    .first_fail_vec (first_fail_vec_b)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a bounded wait is ever miscounted.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison with failure report.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Full sweep on checker A from IDLE/DONE; returns edges from start to done.
  task automatic applyStimulus(input int fault, output int cycles);
    fault_a = fault;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    checkOutput("a_busy_after_start", int'(busy_a), 1);
    checkOutput("a_done_cleared", int'(done_a), 0);
    checkOutput("a_err_cleared", int'(err_cnt_a), 0);
    cycles = 0;
    while (!done_a && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Full sweep on checker B; start from DONE must clear stats on its edge.
  task automatic applyStimulusB(input int fault, output int cycles);
    fault_b = fault;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    checkOutput("b_busy_after_start", int'(busy_b), 1);
    checkOutput("b_done_cleared", int'(done_b), 0);
    checkOutput("b_err_cleared", int'(err_cnt_b), 0);
    checkOutput("b_vld_cleared", int'(first_fail_vld_b), 0);
    cycles = 0;
    while (!done_b && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Bounded wait for checker A's vector to reach a value.
  task automatic waitVecA(input int target);
    int n;
    n = 0;
    while (int'(vec_o_a) != target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("a_vec_reached", int'(vec_o_a), target);
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_vec"},  int'(vec_o_a), 0);
    checkOutput({tag, "_busy"}, int'(busy_a), 0);
    checkOutput({tag, "_done"}, int'(done_a), 0);
    checkOutput({tag, "_pass"}, int'(pass_a), 0);
    checkOutput({tag, "_err"},  int'(err_cnt_a), 0);
    checkOutput({tag, "_vld"},  int'(first_fail_vld_a), 0);
    checkOutput({tag, "_ffv"},  int'(first_fail_vec_a), 0);
  endtask

  task automatic checkCleanA(input string tag, input int cycles);
    checkOutput({tag, "_cycles"}, cycles, 192);
    checkOutput({tag, "_pass"},   int'(pass_a), 1);
    checkOutput({tag, "_err"},    int'(err_cnt_a), 0);
    checkOutput({tag, "_vld"},    int'(first_fail_vld_a), 0);
    checkOutput({tag, "_busy"},   int'(busy_a), 0);
  endtask

  // Main sequence.
  initial begin
    sweep_vec_t tbl[4];
    int cyc;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start_a  = 1'b0;
    abort_a  = 1'b0;
    start_b  = 1'b0;
    abort_b  = 1'b0;
    fault_a  = 0;
    fault_b  = 0;

    // AOI222 has 27 vectors with output 1, so stuck-at-1 fails 37 vectors
    // (first at 000011) and stuck-at-0 fails 27 (first at 000000).
    tbl[0] = '{fault: 0, exp_err: 0,  exp_pass: 1, exp_vld: 0, exp_vec: 0};
    tbl[1] = '{fault: 1, exp_err: 37, exp_pass: 0, exp_vld: 1, exp_vec: 3};
    tbl[2] = '{fault: 2, exp_err: 27, exp_pass: 0, exp_vld: 1, exp_vec: 0};
    tbl[3] = '{fault: 0, exp_err: 0,  exp_pass: 1, exp_vld: 0, exp_vec: 0};

    repeat (3) @(negedge clk);
    checkResetA("reset");
    checkOutput("reset_b_busy", int'(busy_b), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] table-driven sweeps on AOI222 checker");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tbl[i].fault, cyc);
      checkOutput("tbl_cycles", cyc, 192);
      checkOutput("tbl_done", int'(done_a), 1);
      checkOutput("tbl_pass", int'(pass_a), tbl[i].exp_pass);
      checkOutput("tbl_err", int'(err_cnt_a), tbl[i].exp_err);
      checkOutput("tbl_vld", int'(first_fail_vld_a), tbl[i].exp_vld);
      checkOutput("tbl_ffv", int'(first_fail_vec_a), tbl[i].exp_vec);
    end

    $display("[TB] abort from DONE and start+abort collision");
    applyStimulus(2, cyc);
    @(negedge clk) abort_a = 1'b1;
    @(negedge clk) abort_a = 1'b0;
    checkOutput("done_abort_done", int'(done_a), 0);
    checkOutput("done_abort_busy", int'(busy_a), 0);
    checkOutput("done_abort_err_held", int'(err_cnt_a), 27);
    checkOutput("done_abort_vld_held", int'(first_fail_vld_a), 1);
    @(negedge clk) begin
      start_a = 1'b1;
      abort_a = 1'b1;
    end
    @(negedge clk) begin
      start_a = 1'b0;
      abort_a = 1'b0;
    end
    checkOutput("collide_busy", int'(busy_a), 0);
    checkOutput("collide_err_held", int'(err_cnt_a), 27);
    @(negedge clk);
    checkOutput("collide_vec_idle", int'(vec_o_a), 0);

    $display("[TB] start ignored while busy, abort mid-sweep");
    fault_a = 0;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    waitVecA(5);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    checkOutput("busy_start_vec_kept", int'(vec_o_a != 6'd0), 1);
    checkOutput("busy_start_busy", int'(busy_a), 1);
    waitVecA(10);
    abort_a = 1'b1;
    @(negedge clk) abort_a = 1'b0;
    checkOutput("abort_busy", int'(busy_a), 0);
    checkOutput("abort_done", int'(done_a), 0);
    checkOutput("abort_vec", int'(vec_o_a), 0);
    repeat (3) @(negedge clk);
    checkOutput("abort_idle_vec", int'(vec_o_a), 0);
    checkOutput("abort_idle_busy", int'(busy_a), 0);
    applyStimulus(0, cyc);
    checkCleanA("after_abort", cyc);

    $display("[TB] asynchronous reset mid-APPLY");
    applyStimulus(1, cyc);
    fault_a = 0;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    waitVecA(3);
    #2 rst = 1'b1;
    #1 checkResetA("async_rst");
    @(negedge clk) rst = 1'b0;
    applyStimulus(0, cyc);
    checkCleanA("after_rst", cyc);

    $display("[TB] OAI33 checker, SETTLE=1");
    // OAI33 output is 0 when both groups hold a 1: 7*7 = 49 vectors,
    // the lowest being 001001.
    applyStimulusB(0, cyc);
    checkOutput("b_cycles", cyc, 128);
    checkOutput("b_pass", int'(pass_b), 1);
    checkOutput("b_err", int'(err_cnt_b), 0);
    applyStimulusB(1, cyc);
    checkOutput("b_s1_cycles", cyc, 128);
    checkOutput("b_s1_pass", int'(pass_b), 0);
    checkOutput("b_s1_err", int'(err_cnt_b), 49);
    checkOutput("b_s1_ffv", int'(first_fail_vec_b), 9);
    applyStimulusB(0, cyc);
    checkOutput("b_restart_cycles", cyc, 128);
    checkOutput("b_restart_pass", int'(pass_b), 1);
    checkOutput("b_restart_err", int'(err_cnt_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
